divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 14 +
 rtl/divider_step.sv | 28 ++
 rtl/divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    ITER   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// compare against the divisor, conditionally subtract, emit a quotient bit.
module divider_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] div_ext;
  logic             ge;

  always_comb begin
    shifted = {rem_i, dvd_i[WIDTH-1]};
    div_ext = {2'b00, div_i};
    ge      = (shifted >= div_ext);
    rem_o   = ge ? (WIDTH+1)'(shifted - div_ext)
                 : (WIDTH+1)'(shifted);
    dvd_o   = {dvd_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Define DIVIDER_ZERO_CHECK_EN to finish early with a flag on B == 0.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic             dbz_q, dbz_d;
`endif

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        dvd_d   = A;
        div_d   = B;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = ITER;
`ifdef DIVIDER_ZERO_CHECK_EN
        if (B == '0) begin
          state_d = FINISH;
          quo_d   = '1;
          rmd_d   = A;
          dbz_d   = 1'b1;
        end
`endif
      end
      ITER: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q - CW'(1);
        // The last step lands directly in the result registers.
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
          quo_d   = step_dvd;
          rmd_d   = step_rem[WIDTH-1:0];
`ifdef DIVIDER_ZERO_CHECK_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
`ifdef DIVIDER_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
